// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate multiplier command controller:
// command codes, controller states, status-byte bit positions and the
// truncation mask helper.
package approx_mult_pkg;

    // 3-bit command bus encodings
    localparam logic [2:0] CMD_NOP       = 3'b000;
    localparam logic [2:0] CMD_LOAD_A    = 3'b001;
    localparam logic [2:0] CMD_LOAD_B    = 3'b010;
    localparam logic [2:0] CMD_START     = 3'b011;
    localparam logic [2:0] CMD_READ_LO   = 3'b100;
    localparam logic [2:0] CMD_READ_HI   = 3'b101;
    localparam logic [2:0] CMD_READ_STAT = 3'b110;
    localparam logic [2:0] CMD_CLEAR     = 3'b111;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions inside the READ_STAT byte
    localparam int unsigned STAT_BUSY = 7;
    localparam int unsigned STAT_DONE = 6;
    localparam int unsigned STAT_ERR  = 5;

    // Mask that clears the lowest trunc_bits product columns
    function automatic logic [15:0] trunc_mask(input int unsigned trunc_bits);
        return 16'hFFFF << trunc_bits;
    endfunction

endpackage

// File: rtl/approx_pp_term.sv
// Combinational masked partial-product generator: one row of the
// shift-add multiply, with the low TRUNC_BITS columns forced to zero.
module approx_pp_term
    import approx_mult_pkg::*;
#(
    parameter int unsigned TRUNC_BITS = 4
) (
    input  logic [7:0]  a,
    input  logic        b_bit,
    input  logic [2:0]  shift,
    output logic [15:0] term
);

    localparam logic [15:0] MASK = trunc_mask(TRUNC_BITS);

    // Shift A into position and drop the truncated columns when the B bit is set
    always_comb begin
        term = '0;
        if (b_bit) begin
            term = ({8'h00, a} << shift) & MASK;
        end
    end

endmodule

// File: rtl/approx_mult_cmd_ctrl.sv
// Command-driven operand/result controller for the 8-bit approximate
// multiplier. Commands are edge-accepted (executed once per change of the
// command bus), the multiply runs one partial product per clock for eight
// clocks, and results are read back one byte at a time on out_8b.
// Optional build macro: AUTO_READ_EN -- when defined, out_8b is loaded with
// the low product byte on the clock that enters DONE.
module approx_mult_cmd_ctrl
    import approx_mult_pkg::*;
#(
    parameter int unsigned TRUNC_BITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] comm,
    input  logic [7:0] in_8b,
    output logic [7:0] out_8b,
    output logic       busy,
    output logic       done
);

    state_t      state;
    state_t      state_next;
    logic [2:0]  comm_prev;
    logic        accept;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [15:0] acc;
    logic [15:0] product;
    logic [15:0] term;
    logic [15:0] sum;
    logic [2:0]  cnt;
    logic        err;
    logic [7:0]  status;

    approx_pp_term #(
        .TRUNC_BITS(TRUNC_BITS)
    ) u_pp_term (
        .a     (a_reg),
        .b_bit (b_reg[cnt]),
        .shift (cnt),
        .term  (term)
    );

    // Command acceptance, running sum and status byte
    always_comb begin
        accept              = (comm != comm_prev) && (comm != CMD_NOP);
        sum                 = acc + term;
        busy                = (state == CALC);
        done                = (state == DONE);
        status              = '0;
        status[STAT_BUSY]   = busy;
        status[STAT_DONE]   = done;
        status[STAT_ERR]    = err;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE accepts commands exactly like IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept && comm == CMD_START) begin
                    state_next = CALC;
                end else if (accept && comm == CMD_CLEAR) begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (accept && comm == CMD_CLEAR) begin
                    state_next = IDLE;
                end else if (cnt == 3'd7) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Previous command, sampled every cycle for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comm_prev <= CMD_NOP;
        end else begin
            comm_prev <= comm;
        end
    end

    // Operands, accumulator, product, error flag and read-back byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            product <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            out_8b  <= '0;
        end else if (accept && comm == CMD_CLEAR) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            product <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            out_8b  <= '0;
        end else begin
            if (state == CALC) begin
                acc <= sum;
                cnt <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    product <= sum;
`ifdef AUTO_READ_EN
                    out_8b  <= sum[7:0];
`endif
                end
            end
            // An explicit read on the DONE-entry edge still returns the
            // previous product and takes precedence over the auto read.
            if (accept) begin
                case (comm)
                    CMD_LOAD_A: begin
                        if (busy) err <= 1'b1;
                        else      a_reg <= in_8b;
                    end
                    CMD_LOAD_B: begin
                        if (busy) err <= 1'b1;
                        else      b_reg <= in_8b;
                    end
                    CMD_START: begin
                        if (busy) begin
                            err <= 1'b1;
                        end else begin
                            cnt <= '0;
                            acc <= '0;
                        end
                    end
                    CMD_READ_LO:   out_8b <= product[7:0];
                    CMD_READ_HI:   out_8b <= product[15:8];
                    CMD_READ_STAT: out_8b <= status;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_cmd_ctrl.sv
// Self-checking bench for approx_mult_cmd_ctrl (TRUNC_BITS = 4).
// Inputs are driven on the falling edge and outputs sampled there too.
module tb_approx_mult_cmd_ctrl;
    import approx_mult_pkg::*;

    localparam int unsigned TB_TRUNC = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] comm;
    logic [7:0] in_8b;
    logic [7:0] out_8b;
    logic       busy;
    logic       done;

    int checks;
    int fails;
    logic [7:0] model_out;

    approx_mult_cmd_ctrl #(
        .TRUNC_BITS(TB_TRUNC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .comm   (comm),
        .in_8b  (in_8b),
        .out_8b (out_8b),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Exact product minus every low-order column bit dropped from each row
    function automatic logic [15:0] model_product(input logic [7:0] a, input logic [7:0] b);
        int unsigned ai, bi, p, dropped;
        ai = a;
        bi = b;
        p = ai * bi;
        dropped = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) dropped += (ai << i) % (32'd1 << TB_TRUNC);
        end
        return 16'(p - dropped);
    endfunction

    // Present a command for one accepting edge, then return to NOP
    task automatic issue(input logic [2:0] c, input logic [7:0] d);
        @(negedge clk);
        comm  = c;
        in_8b = d;
        @(negedge clk);
        comm  = CMD_NOP;
    endtask

    // Wait (bounded) for done; ok=0 on timeout
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic note_done(input logic [15:0] p);
`ifdef AUTO_READ_EN
        model_out = p[7:0];
`else
        model_out = model_out + 8'd0 + (p[0] & 1'b0);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        comm  = CMD_NOP;
        in_8b = '0;
        model_out = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_8b !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got out=%h busy=%b done=%b expected 00/0/0", out_8b, busy, done);
        end
        rst_n = 1'b1;
        issue(CMD_READ_STAT, 8'h00);
        checks++;
        if (out_8b !== 8'h00) begin
            fails++;
            $display("FAIL reset_stat: got %h expected 00", out_8b);
        end
        issue(CMD_READ_HI, 8'h00);
        checks++;
        if (out_8b !== 8'h00) begin
            fails++;
            $display("FAIL reset_product: got %h expected 00", out_8b);
        end
    endtask

    task automatic test_exact();
        issue(CMD_LOAD_A, 8'hC8);
        @(negedge clk);
        issue(CMD_LOAD_B, 8'h96);
        issue(CMD_START, 8'h00);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL exact_busy_cycle%0d: got busy=%b done=%b expected 1/0", i, busy, done);
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL exact_done: got busy=%b done=%b expected 0/1", busy, done);
        end
        note_done(16'h7530);
        checks++;
        if (out_8b !== model_out) begin
            fails++;
            $display("FAIL exact_out_at_done: got %h expected %h", out_8b, model_out);
        end
        issue(CMD_READ_LO, 8'h00);
        checks++;
        if (out_8b !== 8'h30) begin
            fails++;
            $display("FAIL exact_read_lo: got %h expected 30", out_8b);
        end
        issue(CMD_READ_HI, 8'h00);
        model_out = 8'h75;
        checks++;
        if (out_8b !== 8'h75) begin
            fails++;
            $display("FAIL exact_read_hi: got %h expected 75", out_8b);
        end
    endtask

    task automatic test_approx();
        bit ok;
        issue(CMD_LOAD_A, 8'hFF);
        issue(CMD_LOAD_B, 8'hFF);
        issue(CMD_START, 8'h00);
        wait_done(ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL approx_done_timeout: got done=%b expected 1", done);
        end
        issue(CMD_READ_HI, 8'h00);
        checks++;
        if (out_8b !== 8'hFD) begin
            fails++;
            $display("FAIL approx_read_hi: got %h expected fd", out_8b);
        end
        issue(CMD_READ_LO, 8'h00);
        model_out = 8'hD0;
        checks++;
        if (out_8b !== 8'hD0) begin
            fails++;
            $display("FAIL approx_read_lo: got %h expected d0", out_8b);
        end
    endtask

    task automatic test_busy_err();
        bit ok;
        logic [15:0] exp_p;
        exp_p = model_product(8'h5A, 8'h3C);
        issue(CMD_LOAD_A, 8'h5A);
        issue(CMD_LOAD_B, 8'h3C);
        issue(CMD_START, 8'h00);
        @(negedge clk);
        @(negedge clk);
        comm  = CMD_LOAD_A;
        in_8b = 8'h01;
        @(negedge clk);
        comm  = CMD_NOP;
        wait_done(ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL busy_err_done_timeout: got done=%b expected 1", done);
        end
        issue(CMD_READ_LO, 8'h00);
        checks++;
        if (out_8b !== exp_p[7:0]) begin
            fails++;
            $display("FAIL busy_err_read_lo: got %h expected %h", out_8b, exp_p[7:0]);
        end
        issue(CMD_READ_HI, 8'h00);
        checks++;
        if (out_8b !== exp_p[15:8]) begin
            fails++;
            $display("FAIL busy_err_read_hi: got %h expected %h", out_8b, exp_p[15:8]);
        end
        issue(CMD_READ_STAT, 8'h00);
        checks++;
        if (out_8b !== 8'h60) begin
            fails++;
            $display("FAIL busy_err_stat: got %h expected 60", out_8b);
        end
        issue(CMD_CLEAR, 8'h00);
        model_out = 8'h00;
    endtask

    task automatic test_held_level();
        bit ok;
        logic [15:0] exp_p;
        exp_p = model_product(8'h11, 8'h10);
        @(negedge clk);
        comm  = CMD_LOAD_A;
        in_8b = 8'h11;
        @(negedge clk);
        @(negedge clk);
        in_8b = 8'h22;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        comm  = CMD_NOP;
        issue(CMD_LOAD_B, 8'h10);
        issue(CMD_START, 8'h00);
        wait_done(ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL held_done_timeout: got done=%b expected 1", done);
        end
        issue(CMD_READ_LO, 8'h00);
        checks++;
        if (out_8b !== exp_p[7:0]) begin
            fails++;
            $display("FAIL held_read_lo: got %h expected %h", out_8b, exp_p[7:0]);
        end
        issue(CMD_READ_HI, 8'h00);
        model_out = exp_p[15:8];
        checks++;
        if (out_8b !== exp_p[15:8]) begin
            fails++;
            $display("FAIL held_read_hi: got %h expected %h", out_8b, exp_p[15:8]);
        end
    endtask

    task automatic test_clear();
        bit ok;
        issue(CMD_READ_LO, 8'h00);
        checks++;
        if (out_8b !== 8'h10) begin
            fails++;
            $display("FAIL clear_pre_read: got %h expected 10", out_8b);
        end
        issue(CMD_LOAD_A, 8'h37);
        issue(CMD_LOAD_B, 8'hE5);
        issue(CMD_START, 8'h00);
        repeat (3) @(negedge clk);
        comm = CMD_CLEAR;
        @(negedge clk);
        comm = CMD_NOP;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_8b !== 8'h00) begin
            fails++;
            $display("FAIL clear_abort: got busy=%b done=%b out=%h expected 0/0/00", busy, done, out_8b);
        end
        issue(CMD_READ_HI, 8'h00);
        checks++;
        if (out_8b !== 8'h00) begin
            fails++;
            $display("FAIL clear_read_hi: got %h expected 00", out_8b);
        end
        issue(CMD_READ_STAT, 8'h00);
        checks++;
        if (out_8b !== 8'h00) begin
            fails++;
            $display("FAIL clear_stat: got %h expected 00", out_8b);
        end
        issue(CMD_START, 8'h00);
        wait_done(ok);
        issue(CMD_READ_LO, 8'h00);
        checks++;
        if (!ok || out_8b !== 8'h00) begin
            fails++;
            $display("FAIL clear_operands_zeroed: got ok=%b lo=%h expected 1/00", ok, out_8b);
        end
        model_out = 8'h00;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] a, b;
        logic [15:0] exp_p;
        a = 8'($urandom);
        b = 8'($urandom);
        exp_p = model_product(a, b);
        issue(CMD_LOAD_A, a);
        @(negedge clk);
        comm  = CMD_LOAD_B;
        in_8b = b;
        @(negedge clk);
        comm  = CMD_START;
        @(negedge clk);
        comm  = CMD_NOP;
        wait_done(ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL b2b_done_timeout: got done=%b expected 1", done);
        end
        @(negedge clk);
        comm = CMD_READ_LO;
        @(negedge clk);
        checks++;
        if (out_8b !== exp_p[7:0]) begin
            fails++;
            $display("FAIL b2b_read_lo: got %h expected %h (a=%h b=%h)", out_8b, exp_p[7:0], a, b);
        end
        comm = CMD_READ_HI;
        @(negedge clk);
        checks++;
        if (out_8b !== exp_p[15:8]) begin
            fails++;
            $display("FAIL b2b_read_hi: got %h expected %h", out_8b, exp_p[15:8]);
        end
        comm = CMD_READ_STAT;
        @(negedge clk);
        checks++;
        if (out_8b !== 8'h40) begin
            fails++;
            $display("FAIL b2b_stat: got %h expected 40", out_8b);
        end
        comm = CMD_NOP;
        model_out = 8'h40;
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] a, b;
        logic [15:0] exp_p;
        for (int n = 0; n < 8; n++) begin
            a = 8'($urandom);
            b = 8'($urandom_range(0, 255));
            exp_p = model_product(a, b);
            issue(CMD_LOAD_A, a);
            issue(CMD_LOAD_B, b);
            issue(CMD_START, 8'h00);
            wait_done(ok);
            note_done(exp_p);
            checks++;
            if (!ok || out_8b !== model_out) begin
                fails++;
                $display("FAIL rand%0d_done: got ok=%b out=%h expected 1/%h", n, ok, out_8b, model_out);
            end
            issue(CMD_READ_HI, 8'h00);
            checks++;
            if (out_8b !== exp_p[15:8]) begin
                fails++;
                $display("FAIL rand%0d_hi: got %h expected %h (a=%h b=%h)", n, out_8b, exp_p[15:8], a, b);
            end
            issue(CMD_READ_LO, 8'h00);
            model_out = exp_p[7:0];
            checks++;
            if (out_8b !== exp_p[7:0]) begin
                fails++;
                $display("FAIL rand%0d_lo: got %h expected %h (a=%h b=%h)", n, out_8b, exp_p[7:0], a, b);
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        issue(CMD_LOAD_A, 8'hFF);
        issue(CMD_LOAD_B, 8'hFF);
        issue(CMD_START, 8'h00);
        wait_done(ok);
        issue(CMD_READ_LO, 8'h00);
        checks++;
        if (!ok || out_8b !== 8'hD0) begin
            fails++;
            $display("FAIL async_pre_read: got ok=%b out=%h expected 1/d0", ok, out_8b);
        end
        issue(CMD_START, 8'h00);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_8b !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_immediate: got out=%h busy=%b done=%b expected 00/0/0", out_8b, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_out = 8'h00;
        issue(CMD_READ_LO, 8'h00);
        checks++;
        if (out_8b !== 8'h00) begin
            fails++;
            $display("FAIL async_product_dropped: got %h expected 00", out_8b);
        end
        issue(CMD_READ_STAT, 8'h00);
        checks++;
        if (out_8b !== 8'h00) begin
            fails++;
            $display("FAIL async_stat: got %h expected 00", out_8b);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_exact();
        test_approx();
        test_busy_err();
        test_held_level();
        test_clear();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
